// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment code table, pattern matcher,
// three-digit BCD to binary helper, and the digit sampler state type.
// Segment vectors are active-high {a,b,c,d,e,f,g} with bit6 = a.
package seven_seg_pkg;

  // Active-high segment code for each hex nibble 0..F.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [1:0] {
    SMP_IDLE,
    SMP_SETTLE,
    SMP_CAPTURED
  } smp_state_t;

  // Returns {invalid, nibble}. Unknown patterns (blank included) decode to
  // nibble 0 with the invalid flag set.
  function automatic logic [4:0] seven_seg_match(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b1_0000;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PATTERNS[i]) res = {1'b0, 4'(i)};
    end
    return res;
  endfunction

  function automatic logic [9:0] bcd3_to_bin(input logic [3:0] d2,
                                             input logic [3:0] d1,
                                             input logic [3:0] d0);
    return 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
  endfunction

endpackage

// File: rtl/seg_digit_sampler.sv
// Purpose: watches one multiplexed display slot and emits one sample per
//   stable, one-hot digit-select window (capture pulse, index, active-high seg/dp).
// Latency: capture_o asserts combinationally during the SETTLE_CYCLES-th stable cycle.
// Backpressure: none; the display cannot be stalled, the consumer must keep up.
// Ports: clk/rst (sync, active-high); seg_i/dp_i/dig_sel_i raw display lines;
//   capture_o, idx_o, seg_o, dp_o describe the sample taken on the coming edge.
module seg_digit_sampler
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int COMMON_ANODE  = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_i,
  input  logic                  dp_i,
  input  logic [NUM_DIGITS-1:0] dig_sel_i,
  output logic                  capture_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o
);

  localparam int IN_W  = NUM_DIGITS + 8;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  logic [IN_W-1:0]  in_now;
  logic [IN_W-1:0]  prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  smp_state_t       state_q, state_d;
  logic             same, onehot, capture;
  logic [IDX_W-1:0] idx;

  assign in_now = {dig_sel_i, seg_i, dp_i};

  always_comb begin
    prev_d = in_now;
    same   = (in_now == prev_q);
    onehot = (dig_sel_i != '0) &&
             ((dig_sel_i & (dig_sel_i - NUM_DIGITS'(1))) == '0);

    // cnt_d = number of cycles the current inputs have been stable, minus one.
    if (!same)                cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + CNT_W'(1);

    // A fresh window (!same) may capture immediately when SETTLE_CYCLES is 1,
    // even though the state still says CAPTURED from the previous window.
    capture = onehot && (cnt_d == CNT_MAX) && (!same || state_q != SMP_CAPTURED);

    if (capture)                  state_d = SMP_CAPTURED;
    else if (!onehot)             state_d = SMP_IDLE;
    else if (!same)               state_d = SMP_SETTLE;
    else if (state_q == SMP_IDLE) state_d = SMP_SETTLE;
    else                          state_d = state_q;

    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel_i[i]) idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      state_q <= SMP_IDLE;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign capture_o = capture;
  assign idx_o     = idx;
  assign seg_o     = (COMMON_ANODE != 0) ? ~seg_i : seg_i;
  assign dp_o      = (COMMON_ANODE != 0) ? ~dp_i  : dp_i;

endmodule

// File: rtl/seg_frame_decoder.sv
// Purpose: recovers the hex digits shown on a multiplexed seven-segment display
//   and presents each complete frame on a valid/ready interface.
// Latency: frame outputs load on the edge ending the last digit's SETTLE_CYCLES-th stable cycle.
// Backpressure: frame held until accepted; a newer frame overwrites it and sets sticky overrun_o.
// Ports: clk, rst (sync active-high); seg_i/dp_i/dig_sel_i display lines;
//   digits_o/dp_o/invalid_o frame data; frame_valid_o/frame_ready_i handshake; overrun_o.
//   Optional macro SEG_BCD_TO_BIN_EN adds bin_o (d2*100+d1*10+d0) and bin_err_o.
module seg_frame_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int COMMON_ANODE  = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_i,
  input  logic                    dp_i,
  input  logic [NUM_DIGITS-1:0]   dig_sel_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   dp_o,
  output logic [NUM_DIGITS-1:0]   invalid_o,
  output logic                    frame_valid_o,
  input  logic                    frame_ready_i,
  output logic                    overrun_o
`ifdef SEG_BCD_TO_BIN_EN
  ,
  output logic [9:0]              bin_o,
  output logic                    bin_err_o
`endif
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic             samp_cap;
  logic [IDX_W-1:0] samp_idx;
  logic [6:0]       samp_seg;
  logic             samp_dp;

  seg_digit_sampler #(
    .NUM_DIGITS   (NUM_DIGITS),
    .COMMON_ANODE (COMMON_ANODE),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .IDX_W        (IDX_W)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .seg_i     (seg_i),
    .dp_i      (dp_i),
    .dig_sel_i (dig_sel_i),
    .capture_o (samp_cap),
    .idx_o     (samp_idx),
    .seg_o     (samp_seg),
    .dp_o      (samp_dp)
  );

  logic [4*NUM_DIGITS-1:0] shadow_nib_q, shadow_nib_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_inv_q, shadow_inv_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_set;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   inv_q, inv_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic [4:0]              match;
  logic                    frame_done;
`ifdef SEG_BCD_TO_BIN_EN
  logic [9:0]              bin_q, bin_d;
  logic                    bin_err_q, bin_err_d;
`endif

  always_comb begin
    shadow_nib_d = shadow_nib_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_inv_d = shadow_inv_q;
    seen_d       = seen_q;
    digits_d     = digits_q;
    dp_d         = dp_q;
    inv_d        = inv_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
`ifdef SEG_BCD_TO_BIN_EN
    bin_d        = bin_q;
    bin_err_d    = bin_err_q;
`endif

    match      = seven_seg_match(samp_seg);
    seen_set   = seen_q | (NUM_DIGITS'(1) << samp_idx);
    frame_done = samp_cap && (seen_set == '1);

    if (valid_q && frame_ready_i) valid_d = 1'b0;

    if (samp_cap) begin
      shadow_nib_d[{samp_idx, 2'b00} +: 4] = match[3:0];
      shadow_inv_d[samp_idx]               = match[4];
      shadow_dp_d[samp_idx]                = samp_dp;
      seen_d                               = seen_set;
    end

    // Outputs take the shadow with the new sample already merged in, so the
    // capturing edge of the last digit also completes the frame.
    if (frame_done) begin
      digits_d = shadow_nib_d;
      dp_d     = shadow_dp_d;
      inv_d    = shadow_inv_d;
      valid_d  = 1'b1;
      seen_d   = '0;
      if (valid_q && !frame_ready_i) overrun_d = 1'b1;
`ifdef SEG_BCD_TO_BIN_EN
      bin_err_d = (shadow_nib_d[3:0] > 4'd9) || (shadow_nib_d[7:4] > 4'd9) ||
                  (shadow_nib_d[11:8] > 4'd9) || (|shadow_inv_d[2:0]);
      bin_d     = bin_err_d ? 10'd0 :
                  bcd3_to_bin(shadow_nib_d[11:8], shadow_nib_d[7:4], shadow_nib_d[3:0]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_nib_q <= '0;
      shadow_dp_q  <= '0;
      shadow_inv_q <= '0;
      seen_q       <= '0;
      digits_q     <= '0;
      dp_q         <= '0;
      inv_q        <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SEG_BCD_TO_BIN_EN
      bin_q        <= '0;
      bin_err_q    <= 1'b0;
`endif
    end else begin
      shadow_nib_q <= shadow_nib_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_inv_q <= shadow_inv_d;
      seen_q       <= seen_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      inv_q        <= inv_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
`ifdef SEG_BCD_TO_BIN_EN
      bin_q        <= bin_d;
      bin_err_q    <= bin_err_d;
`endif
    end
  end

  assign digits_o      = digits_q;
  assign dp_o          = dp_q;
  assign invalid_o     = inv_q;
  assign frame_valid_o = valid_q;
  assign overrun_o     = overrun_q;
`ifdef SEG_BCD_TO_BIN_EN
  assign bin_o         = bin_q;
  assign bin_err_o     = bin_err_q;
`endif

endmodule
